// File: rtl/mips32_pkg.sv
// Shared mips32 pipeline definitions: fetch FSM states, boot/exception addresses, NOP encoding.
package mips32_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF       = 32'hBFC0_0000;
  localparam logic [XLEN-1:0] EXC_VEC_TLB_REFILL = 32'hBFC0_0200;
  localparam logic [XLEN-1:0] EXC_VEC_GENERAL    = 32'hBFC0_0380;
  localparam logic [XLEN-1:0] NOP_INST_DEF       = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } fetch_state_t;

  // Instruction addresses are word aligned; low two bits are ignored.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// PC generation and instruction-memory fetch stage feeding the IF/ID register.
// One instruction at a time is either in flight or presented; redirects come from ID and later stages.
module if_fetch_unit
  import mips32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            exc_req,
  input  logic [XLEN-1:0] exc_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] IF_inst,
  output logic [XLEN-1:0] IF_PC,
  output logic [XLEN-1:0] IF_PCnext,
  output logic            IF_stall,
  output logic            IF_flush
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  fetch_state_t    state_q, state_n;
  logic [XLEN-1:0] pc_q, pc_n;
  logic [XLEN-1:0] req_addr_q, req_addr_n;
  logic            drop_q, drop_n;
  logic            out_valid_q, out_valid_n;
  logic [XLEN-1:0] inst_n, out_pc_n, out_pcnext_n;

  logic            redirect;
  logic [XLEN-1:0] redirect_addr;
  logic [XLEN-1:0] issue_addr;
  logic            issue;

  // Exceptions squash whatever IF/ID would capture this cycle.
  assign IF_flush = exc_req;

  always_comb begin
    state_n      = state_q;
    pc_n         = pc_q;
    req_addr_n   = req_addr_q;
    drop_n       = drop_q;
    out_valid_n  = out_valid_q;
    inst_n       = IF_inst;
    out_pc_n     = IF_PC;
    out_pcnext_n = IF_PCnext;
    issue        = 1'b0;

    redirect      = exc_req | br_taken;
    redirect_addr = word_align(exc_req ? exc_target : br_target);
    // A fetch issued in the same cycle as a redirect goes straight to the new target.
    issue_addr    = redirect ? redirect_addr : pc_q;

    if (redirect) begin
      pc_n = redirect_addr;
    end

    case (state_q)
      IDLE: begin
        issue = 1'b1;
      end
      REQ: begin
        if (exc_req) begin
          drop_n = 1'b1;
        end
        if (imem_gnt) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (exc_req || drop_q) begin
            drop_n = 1'b0;
            issue  = 1'b1;
          end else begin
            inst_n       = imem_rdata;
            out_pc_n     = req_addr_q;
            out_pcnext_n = req_addr_q + PC_STEP;
            out_valid_n  = 1'b1;
            state_n      = OUT;
          end
        end else if (exc_req) begin
          drop_n = 1'b1;
        end
      end
      OUT: begin
        if (exc_req || !id_stall) begin
          out_valid_n = 1'b0;
          issue       = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (issue) begin
      req_addr_n = issue_addr;
      pc_n       = issue_addr + PC_STEP;
      state_n    = REQ;
    end

    if (!out_valid_n) begin
      inst_n = NOP_INST;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= '0;
      drop_q      <= 1'b0;
      out_valid_q <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      IF_inst     <= NOP_INST;
      IF_PC       <= '0;
      IF_PCnext   <= '0;
      IF_stall    <= 1'b1;
    end else begin
      state_q     <= state_n;
      pc_q        <= pc_n;
      req_addr_q  <= req_addr_n;
      drop_q      <= drop_n;
      out_valid_q <= out_valid_n;
      imem_req    <= (state_n == REQ);
      imem_addr   <= (state_n == REQ) ? req_addr_n : '0;
      IF_inst     <= inst_n;
      IF_PC       <= out_pc_n;
      IF_PCnext   <= out_pcnext_n;
      IF_stall    <= !out_valid_n;
    end
  end

endmodule
